// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch for the single-issue CPU.
// Owns the PC, requests instruction memory over a req/ack handshake and
// presents a registered instruction (with opcode split out) to control.
// Optional feature macro: FETCH_SKID_EN adds a one-entry skid buffer and
// the BLOCK state. Without it, an ack that cannot be accepted is dropped
// and the same address is fetched again.
//
// state  | meaning
// FETCH  | request outstanding at imem_addr (= pc)
// BLOCK  | skid holds one word, request idle until stall releases
// SQUASH | waiting out a request made stale by a branch; its data is dropped
module fetch_stage #(
  parameter int               ADDR_W     = 8,
  parameter int               INSTR_W    = 16,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter logic [3:0]       NOP_OPCODE = 4'hF
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [3:0]         if_opcode,
  output logic [ADDR_W-1:0]  if_pc
);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    BLOCK  = 2'd1,
    SQUASH = 2'd2
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   pc;
  logic [ADDR_W-1:0]   pc_next;
  logic                acked;
  logic                slot_free;

`ifdef FETCH_SKID_EN
  logic [INSTR_W-1:0]  skid_data;
  logic [ADDR_W-1:0]   skid_pc;
  logic                skid_valid;
`endif

  // An ack only counts while a request is actually out.
  assign acked     = imem_req & imem_ack;
  assign slot_free = ~if_valid | ~stall;
  assign pc_next   = pc + ADDR_W'(1);
  assign if_opcode = if_valid ? if_instr[INSTR_W-1 -: 4] : NOP_OPCODE;

  // Fetch sequencing: PC, request, output slot and skid buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FETCH;
      pc        <= RESET_PC;
      imem_addr <= RESET_PC;
      imem_req  <= 1'b0;
      if_valid  <= 1'b0;
      if_instr  <= '0;
      if_pc     <= '0;
`ifdef FETCH_SKID_EN
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_pc    <= '0;
`endif
    end else if (branch_taken) begin
      // Flush wins over stall; an in-flight request must still be retired.
      pc       <= branch_target;
      if_valid <= 1'b0;
      imem_req <= 1'b1;
`ifdef FETCH_SKID_EN
      skid_valid <= 1'b0;
`endif
      if (imem_req && !imem_ack) begin
        state <= SQUASH;
      end else begin
        state     <= FETCH;
        imem_addr <= branch_target;
      end
    end else begin
      case (state)
        FETCH: begin
          imem_req <= 1'b1;
          if (acked) begin
            if (slot_free) begin
              if_instr  <= imem_data;
              if_pc     <= imem_addr;
              if_valid  <= 1'b1;
              pc        <= pc_next;
              imem_addr <= pc_next;
            end
`ifdef FETCH_SKID_EN
            else begin
              skid_data  <= imem_data;
              skid_pc    <= imem_addr;
              skid_valid <= 1'b1;
              pc         <= pc_next;
              imem_addr  <= pc_next;
              imem_req   <= 1'b0;
              state      <= BLOCK;
            end
`endif
          end else if (slot_free) begin
            if_valid <= 1'b0;
          end
        end
        BLOCK: begin
`ifdef FETCH_SKID_EN
          if (!stall) begin
            if_instr   <= skid_data;
            if_pc      <= skid_pc;
            if_valid   <= skid_valid;
            skid_valid <= 1'b0;
            imem_req   <= 1'b1;
            state      <= FETCH;
          end
`else
          imem_req <= 1'b1;
          state    <= FETCH;
`endif
        end
        SQUASH: begin
          imem_req <= 1'b1;
          if (acked) begin
            state     <= FETCH;
            imem_addr <= pc;
          end
        end
        default: begin
          imem_req <= 1'b1;
          state    <= FETCH;
        end
      endcase
    end
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage for the single-issue CPU. It owns the program counter and issues requests to instruction memory over a req/ack handshake. It presents a registered instruction word, with its 4-bit opcode split out, directly to the control unit. It absorbs downstream stalls with a one-entry skid buffer and flushes on taken branches.

## Interface
- `ADDR_W`, 8: PC / instruction-memory address width in words.
- `INSTR_W`, 16: instruction width; the opcode is bits `[INSTR_W-1 -: 4]`.
- `RESET_PC`, 0: PC value after reset.
- `NOP_OPCODE`, 4'hF: opcode driven while no valid instruction is presented.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `imem_req` output 1: fetch request; held until `imem_ack`.
- `imem_addr` output ADDR_W: registered request address; stable while `imem_req`=1.
- `imem_ack` input 1: memory returns `imem_data` this cycle; ignored when `imem_req`=0.
- `imem_data` input INSTR_W: instruction word, valid with `imem_ack`.
- `stall` input 1: downstream cannot accept a new instruction.
- `branch_taken` input 1: one-cycle redirect pulse.
- `branch_target` input ADDR_W: redirect address, valid with `branch_taken`.
- `if_valid` output 1: `if_instr` / `if_pc` hold a live instruction.
- `if_instr` output INSTR_W: registered instruction.
- `if_opcode` output 4: `if_instr[INSTR_W-1 -: 4]` when `if_valid`, else `NOP_OPCODE`.
- `if_pc` output ADDR_W: address of `if_instr`.

## Operation
- Registers: `pc`, `imem_addr`, `if_instr`, `if_pc`, `if_valid`, `skid_data`, `skid_pc`, `skid_valid`, and the state.
- Output slot is free when `if_valid`=0 or `stall`=0.
- State FETCH: `imem_req`=1, `imem_addr`=`pc`. On ack:
  - If the slot is free: load `if_instr`/`if_pc`, set `if_valid`=1.
  - Otherwise: load the skid buffer, set `skid_valid`=1, go to BLOCK.
  - In both cases `pc`←`pc`+1, and the next request goes out at the new `pc`.
  - If there is no ack and the slot is free: `if_valid`←0.
- State BLOCK: `imem_req`=0. When `stall`=0: move the skid entry into the slot, clear `skid_valid`, go to FETCH.
- State SQUASH: `imem_req`=1 at the old `imem_addr`. On ack, discard the data and go to FETCH at `pc`.
- `branch_taken`, in any state:
  - Next cycle: `if_valid`=0, `skid_valid`=0, `pc`=`branch_target`.
  - If a request is outstanding without ack this cycle: go to SQUASH.
  - Otherwise: go to FETCH, with `imem_addr`=`branch_target`.
- `branch_taken` during SQUASH only updates `pc`.
- Priority: `rst` > `branch_taken` > `stall`. A branch flushes even while stalled.
- `pc` wraps modulo 2^ADDR_W, from all-ones to 0, silently.

## Timing
- Reset values:
  - `pc`=`RESET_PC`, `imem_addr`=`RESET_PC`, state=FETCH.
  - `imem_req`=0 while `rst`=1.
  - `if_valid`=0, `if_instr`=0, `if_pc`=0, `if_opcode`=`NOP_OPCODE`, `skid_valid`=0.
- First request is asserted in the cycle after `rst` deasserts.
- `imem_ack` to `if_valid`: 1 cycle. With zero-wait memory, throughput is one instruction per cycle.
- `branch_taken` at cycle N:
  - Bubble (`if_valid`=0) at N+1.
  - Target request at N+1 (or after the squashed ack).
  - Target instruction is valid no earlier than N+2.
- Simultaneous ack and branch: the ack data is discarded; no SQUASH.
- `rst` mid-request: the request is abandoned and any later ack is ignored.
- `stall`=1 with `if_valid`=1: outputs hold bit-stable.

## Configuration
- `FETCH_SKID_EN` defined: skid buffer and BLOCK state are present, as described above.
- Not defined: no skid registers.
  - An ack arriving while the slot is not free is discarded, and `pc` is not incremented, so the same address is refetched.
  - FETCH keeps requesting.
  - Functionally identical instruction stream; lower throughput under stall.

## Test plan
- Reset, `RESET_PC`=0, zero-wait ack, memory[i]=16'h1000+i -> `if_instr` 1000, 1001, 1002 on consecutive cycles; `if_pc` 0, 1, 2; `if_opcode`=1.
- 3-cycle ack latency -> `imem_addr` stable while `imem_req` is held; one instruction per 3 cycles.
- `stall`=1 for 4 cycles with skid enabled -> `if_instr` held; one extra word buffered; `imem_req`=0 in BLOCK; on release, words appear in order with no loss or duplicate. Without the macro: same order, the address is refetched.
- `branch_taken` with target 8'h40 while stalled and the skid is full -> next cycle `if_valid`=0, `if_opcode`=F; next `if_pc`=40.
- Branch to 8'h20 while a request is outstanding, ack 2 cycles later -> the acked word is never presented; the first valid `if_pc`=20.
- `pc` at 8'hFF -> the next fetch address is 00; `rst` pulsed mid-request -> `if_valid`=0 and fetch restarts at `RESET_PC`.
